// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready bus between the fetch sequencer
// (master) and instruction memory (slave).
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC, issues instruction fetches, buffers one word
// across stalls and loads the F/D register.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0000_4ffc
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      br_valid,
    input  logic [31:0]               br_target,
    input  logic                      exc_req,
    input  logic                      eret_req,
    input  logic [31:0]               epc,
    fetch_sequencer_if.master         imem,
    output logic                      if_valid,
    output logic [31:0]               if_instr,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_pc8,
    output logic                      if_adel
);

    typedef enum logic [1:0] {
        FETCH,
        BUFFERED,
        DRAIN,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        pend_v;
    logic [31:0] pend_tgt;

    logic        addr_ok;
    logic        flush;
    logic        br_now;
    logic [31:0] flush_tgt;
    logic [31:0] next_pc;

    assign addr_ok = (pc[1:0] == 2'b00) && (pc >= IMEM_BASE) && (pc <= IMEM_LIMIT);
    assign flush     = exc_req | eret_req;
    assign flush_tgt = exc_req ? EXC_VECTOR : epc;
    assign br_now    = br_valid & ~stall;

    // A redirect seen this cycle beats one latched while the fetch was waiting
    assign next_pc = br_now ? br_target :
                     pend_v ? pend_tgt  : pc + 32'd4;

    // Request drops the moment reset asserts; memory tolerates the abandon
    assign imem.imem_req  = reset_n &&
                            ((state == FETCH && addr_ok) || state == DRAIN);
    assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;

    assign if_pc8 = if_pc + 32'd8;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            buf_instr  <= 32'h0;
            buf_pc     <= RESET_PC;
            pend_v     <= 1'b0;
            pend_tgt   <= 32'h0;
            if_valid   <= 1'b0;
            if_instr   <= 32'h0;
            if_pc      <= RESET_PC;
            if_adel    <= 1'b0;
        end else if (flush) begin
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
            pend_v   <= 1'b0;
            pc       <= flush_tgt;
            if (state == DRAIN) begin
                if (imem.imem_ready) state <= FETCH;
            end else if (imem.imem_req && !imem.imem_ready) begin
                state      <= DRAIN;
                drain_addr <= pc;
            end else begin
                state <= FETCH;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (!addr_ok) begin
                        if (!stall) begin
                            if_valid <= 1'b1;
                            if_instr <= 32'h0;
                            if_pc    <= pc;
                            if_adel  <= 1'b1;
                            state    <= FAULT;
                        end
                    end else if (imem.imem_ready) begin
                        pc     <= next_pc;
                        pend_v <= 1'b0;
                        if (stall) begin
                            buf_instr <= imem.imem_rdata;
                            buf_pc    <= pc;
                            state     <= BUFFERED;
                        end else begin
                            if_valid <= 1'b1;
                            if_instr <= imem.imem_rdata;
                            if_pc    <= pc;
                            if_adel  <= 1'b0;
                        end
                    end else begin
                        if (br_now) begin
                            pend_v   <= 1'b1;
                            pend_tgt <= br_target;
                        end
                        if (!stall) begin
                            if_valid <= 1'b0;
                            if_adel  <= 1'b0;
                        end
                    end
                end
                BUFFERED: begin
                    if (br_now) pc <= br_target;
                    if (!stall) begin
                        if_valid <= 1'b1;
                        if_instr <= buf_instr;
                        if_pc    <= buf_pc;
                        if_adel  <= 1'b0;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ready) state <= FETCH;
                end
                FAULT: begin
                    if (!stall) begin
                        if_valid <= 1'b0;
                        if_adel  <= 1'b0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural fetch model is checked
// against the DUT every cycle, with literal expectations pinning key points.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_4ffc;
    localparam logic [31:0] SCRAMBLE   = 32'ha5a5_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc8;
    logic        if_adel;

    fetch_sequencer_if bus ();

    assign bus.imem_rdata = bus.imem_addr ^ SCRAMBLE;

    fetch_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc       (epc),
        .imem      (bus.master),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_pc8    (if_pc8),
        .if_adel   (if_adel)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit          live = 1'b0;
    logic [31:0] m_pc;
    bit          m_draining;
    logic [31:0] m_drain_addr;
    bit          m_holding;
    logic [31:0] m_hold_instr;
    logic [31:0] m_hold_pc;
    bit          m_faulted;
    logic [31:0] m_redirect[$];
    bit          fd_v;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    bit          fd_adel;

    function automatic bit legal(input logic [31:0] a);
        return a[1:0] == 2'b00 && a >= IMEM_BASE && a <= IMEM_LIMIT;
    endfunction

    function automatic bit want_req();
        if (m_holding || m_faulted) return 1'b0;
        return m_draining || legal(m_pc);
    endfunction

    function automatic logic [31:0] want_addr();
        return m_draining ? m_drain_addr : m_pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("imem_req", 32'(bus.imem_req), 32'(want_req()));
        if (want_req()) chk("imem_addr", bus.imem_addr, want_addr());
        chk("if_valid", 32'(if_valid), 32'(fd_v));
        chk("if_instr", if_instr, fd_instr);
        chk("if_pc", if_pc, fd_pc);
        chk("if_pc8", if_pc8, fd_pc + 32'd8);
        chk("if_adel", 32'(if_adel), 32'(fd_adel));
    endtask

    task automatic drive(input logic rn, input logic st, input logic br,
                         input logic [31:0] bt, input logic ex, input logic er,
                         input logic [31:0] ep, input logic rd);
        @(negedge clk);
        reset_n        = rn;
        stall          = st;
        br_valid       = br;
        br_target      = bt;
        exc_req        = ex;
        eret_req       = er;
        epc            = ep;
        bus.imem_ready = rd;
        #1;
        if (!reset_n) chk("req_in_reset", 32'(bus.imem_req), 32'd0);
        else if (live) compare();
    endtask

    task automatic tick();
        bit       req_now;
        bit       brn;
        logic [31:0] nxt;
        @(posedge clk);
        req_now = want_req();
        brn     = br_valid && !stall;
        if (!reset_n) begin
            live       = 1'b1;
            m_pc       = RESET_PC;
            m_draining = 1'b0;
            m_holding  = 1'b0;
            m_faulted  = 1'b0;
            m_redirect.delete();
            fd_v       = 1'b0;
            fd_instr   = 32'h0;
            fd_pc      = RESET_PC;
            fd_adel    = 1'b0;
        end else if (exc_req || eret_req) begin
            fd_v      = 1'b0;
            fd_adel   = 1'b0;
            m_holding = 1'b0;
            m_faulted = 1'b0;
            m_redirect.delete();
            if (m_draining) begin
                m_draining = !bus.imem_ready;
            end else if (req_now && !bus.imem_ready) begin
                m_draining   = 1'b1;
                m_drain_addr = m_pc;
            end
            m_pc = exc_req ? EXC_VECTOR : epc;
        end else if (m_draining) begin
            if (bus.imem_ready) m_draining = 1'b0;
        end else if (m_faulted) begin
            if (!stall) begin
                fd_v    = 1'b0;
                fd_adel = 1'b0;
            end
        end else if (m_holding) begin
            if (brn) m_pc = br_target;
            if (!stall) begin
                fd_v      = 1'b1;
                fd_instr  = m_hold_instr;
                fd_pc     = m_hold_pc;
                fd_adel   = 1'b0;
                m_holding = 1'b0;
            end
        end else if (!legal(m_pc)) begin
            if (!stall) begin
                fd_v      = 1'b1;
                fd_instr  = 32'h0;
                fd_pc     = m_pc;
                fd_adel   = 1'b1;
                m_faulted = 1'b1;
            end
        end else if (bus.imem_ready) begin
            if (brn) nxt = br_target;
            else if (m_redirect.size() > 0) nxt = m_redirect[0];
            else nxt = m_pc + 32'd4;
            m_redirect.delete();
            if (stall) begin
                m_holding    = 1'b1;
                m_hold_instr = m_pc ^ SCRAMBLE;
                m_hold_pc    = m_pc;
            end else begin
                fd_v     = 1'b1;
                fd_instr = m_pc ^ SCRAMBLE;
                fd_pc    = m_pc;
                fd_adel  = 1'b0;
            end
            m_pc = nxt;
        end else begin
            if (brn) begin
                m_redirect.delete();
                m_redirect.push_back(br_target);
            end
            if (!stall) begin
                fd_v    = 1'b0;
                fd_adel = 1'b0;
            end
        end
    endtask

    // Plain cycle: no stall, branch or flush, ready as given
    task automatic run(input logic rd);
        drive(1, 0, 0, 0, 0, 0, 0, rd);
    endtask

    initial begin
        reset_n        = 1'b0;
        stall          = 1'b0;
        br_valid       = 1'b0;
        br_target      = 32'h0;
        exc_req        = 1'b0;
        eret_req       = 1'b0;
        epc            = 32'h0;
        bus.imem_ready = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();

        // zero-wait sequential fetch, then a 2-cycle wait on 3004
        run(1);
        chk("lit_a3000", bus.imem_addr, 32'h3000);
        chk("lit_pc_rst", if_pc, 32'h3000);
        chk("lit_v_rst", 32'(if_valid), 32'd0);
        tick();
        run(0);
        chk("lit_a3004", bus.imem_addr, 32'h3004);
        chk("lit_pc3000", if_pc, 32'h3000);
        tick();
        run(0);
        chk("lit_wait_v0", 32'(if_valid), 32'd0);
        tick();
        run(1);
        chk("lit_a3004_hold", bus.imem_addr, 32'h3004);
        tick();

        // branch while delay slot 3008 is outstanding
        drive(1, 0, 1, 32'h3100, 0, 0, 0, 0);
        chk("lit_a3008", bus.imem_addr, 32'h3008);
        chk("lit_pc8_300c", if_pc8, 32'h300c);
        tick();
        run(1); tick();
        run(1);
        chk("lit_a3100", bus.imem_addr, 32'h3100);
        chk("lit_slot3008", if_pc, 32'h3008);
        tick();

        // completion under a 3-cycle stall
        drive(1, 1, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        chk("lit_buf_req0", 32'(bus.imem_req), 32'd0);
        chk("lit_hold3100", if_pc, 32'h3100);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 1); tick();
        run(0); tick();

        // exception during an outstanding fetch of 3108
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        chk("lit_a3108", bus.imem_addr, 32'h3108);
        chk("lit_pc3104", if_pc, 32'h3104);
        tick();
        run(0);
        chk("lit_drain_addr", bus.imem_addr, 32'h3108);
        chk("lit_drain_v0", 32'(if_valid), 32'd0);
        tick();
        run(1); tick();
        drive(1, 0, 0, 0, 1, 1, 32'h3200, 1);
        chk("lit_a4180", bus.imem_addr, 32'h4180);
        tick();
        run(1);
        chk("lit_both_4180", bus.imem_addr, 32'h4180);
        tick();

        // eret to a misaligned EPC
        drive(1, 0, 0, 0, 0, 1, 32'h3002, 1); tick();
        run(1);
        chk("lit_mis_req0", 32'(bus.imem_req), 32'd0);
        tick();
        run(1);
        chk("lit_adel_pc", if_pc, 32'h3002);
        chk("lit_adel", 32'(if_adel), 32'd1);
        chk("lit_adel_instr", if_instr, 32'h0);
        tick();
        run(1);
        chk("lit_fault_v0", 32'(if_valid), 32'd0);
        tick();
        drive(1, 0, 0, 0, 1, 0, 0, 0); tick();
        run(0);
        chk("lit_exit_4180", bus.imem_addr, 32'h4180);
        tick();

        // upper bound: 4ffc legal, 5000 not
        drive(1, 0, 0, 0, 0, 1, 32'h4ffc, 0); tick();
        run(1); tick();
        run(1);
        chk("lit_a4ffc", bus.imem_addr, 32'h4ffc);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        chk("lit_5000_req0", 32'(bus.imem_req), 32'd0);
        tick();
        run(0); tick();
        run(0);
        chk("lit_5000_pc", if_pc, 32'h5000);
        tick();

        // lower bound: 2ffc illegal, then back into range
        drive(1, 0, 0, 0, 0, 1, 32'h2ffc, 0); tick();
        run(0);
        chk("lit_2ffc_req0", 32'(bus.imem_req), 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 32'h3004, 0); tick();
        run(0);
        chk("lit_a3004_again", bus.imem_addr, 32'h3004);
        tick();

        // reset mid-fetch, then a branch taken while a word is buffered
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        run(1);
        chk("lit_after_rst", bus.imem_addr, 32'h3000);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 0, 1, 32'h3200, 0, 0, 0, 0); tick();
        run(1);
        chk("lit_a3200", bus.imem_addr, 32'h3200);
        chk("lit_buf3004", if_pc, 32'h3004);
        tick();
        run(1); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
